keccak_padder64: RTL and testbench

- Message padder for a Keccak-f[1600] SHA3-512-rate core (r = 576 bits = 9 x 64-bit words).
- Accepts the message as 64-bit words, applies SHA3 padding (domain byte 0x06, final bit 0x80), and presents full 576-bit blocks to the permutation engine.
- Uses a valid/ack handshake on both sides.

---
 rtl/keccak_pkg.sv | 28 ++
 rtl/pad_last_word64.sv | 32 +++
 rtl/keccak_padder64.sv | 105 ++++++++++
 tb/tb_keccak_padder64.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and types for the SHA3-512 message padder.
//   WORD_W      : width of one message word
//   RATE_W      : width of one rate block handed to Keccak-f[1600]
//   RATE_WORDS  : number of words in one rate block
//   SHA3_DOMAIN : SHA3 domain suffix plus the first padding bit
//   PAD_LAST    : final padding bit, OR-ed into the last byte of a block
package keccak_pkg;

  localparam int WORD_W     = 64;
  localparam int RATE_W     = 576;
  localparam int RATE_WORDS = 9;
  localparam int CNT_W      = 4;

  localparam logic [7:0] SHA3_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_LAST    = 8'h80;

  // Word count at which the block is complete, and the index of its last slot.
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RATE_WORDS);
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(RATE_WORDS - 1);

  // What kind of word is being shifted into the block this cycle.
  typedef enum logic [1:0] {
    WORD_NORMAL,  // full message word taken as-is
    WORD_LAST,    // final partial word with the domain byte inserted
    WORD_FILL     // zero word appended after the message ended
  } word_kind_e;

endpackage

// File: rtl/pad_last_word64.sv
// Builds the final message word: keeps the first byte_num message bytes
// (byte 0 is in[63:56]), places the domain byte right after them and
// zeroes the remainder.
//   in       : final message word, bytes past byte_num are don't-care
//   byte_num : number of valid message bytes in `in` (0..7)
//   out      : padded word
module pad_last_word64
  import keccak_pkg::*;
#(
  parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN
) (
  input  logic [WORD_W-1:0] in,
  input  logic [2:0]        byte_num,
  output logic [WORD_W-1:0] out
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    out = '0;
    unique case (byte_num)
      3'd0: out = {DOMAIN_BYTE, 56'h0};
      3'd1: out = {in[63:56], DOMAIN_BYTE, 48'h0};
      3'd2: out = {in[63:48], DOMAIN_BYTE, 40'h0};
      3'd3: out = {in[63:40], DOMAIN_BYTE, 32'h0};
      3'd4: out = {in[63:32], DOMAIN_BYTE, 24'h0};
      3'd5: out = {in[63:24], DOMAIN_BYTE, 16'h0};
      3'd6: out = {in[63:16], DOMAIN_BYTE, 8'h0};
      3'd7: out = {in[63:8],  DOMAIN_BYTE};
    endcase
  end

endmodule

// File: rtl/keccak_padder64.sv
// SHA3-512 message padder: collects 64-bit message words into 576-bit rate
// blocks, applies SHA3 padding to the final block and hands each full block
// to the permutation engine with a valid/ack handshake.
//   clk         : clock
//   reset       : synchronous active-high reset, discards any partial block
//   in          : message word, byte 0 in in[63:56]
//   in_ready    : `in` is valid this cycle
//   is_last     : `in` is the final (partial) message word
//   byte_num    : valid bytes in the final word (0..7)
//   buffer_full : block holds 9 words; no input is accepted
//   out         : assembled block, first accepted word in out[575:512]
//   out_ready   : `out` holds a complete block
//   f_ack       : consumer has taken the block
module keccak_padder64
  import keccak_pkg::*;
#(
  parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in,
  input  logic              in_ready,
  input  logic              is_last,
  input  logic [2:0]        byte_num,
  output logic              buffer_full,
  output logic [RATE_W-1:0] out,
  output logic              out_ready,
  input  logic              f_ack
);

  logic [CNT_W-1:0]  count;
  logic              pad;    // message ended, remaining slots get zero fill
  logic              done;   // padded final block produced, input closed
  logic [WORD_W-1:0] last_word;
  logic [WORD_W-1:0] next_word;
  word_kind_e        kind;
  logic              update;
  logic              final_slot;

  pad_last_word64 #(
    .DOMAIN_BYTE (DOMAIN_BYTE)
  ) u_pad_last (
    .in       (in),
    .byte_num (byte_num),
    .out      (last_word)
  );

  assign buffer_full = (count == FULL_COUNT);
  assign out_ready   = buffer_full;

  // Acknowledge wins over input; fill words advance without in_ready.
  assign update = ~f_ack & ~buffer_full & ~done & (in_ready | pad);

  always_comb begin
    kind = WORD_NORMAL;
    if (pad) begin
      kind = WORD_FILL;
    end else if (is_last) begin
      kind = WORD_LAST;
    end
  end

  // The final padding bit lands in the last byte of the block, so it only
  // applies when the padded portion reaches slot 8.
  assign final_slot = (count == LAST_SLOT) && (kind != WORD_NORMAL);

  always_comb begin
    next_word = in;
    unique case (kind)
      WORD_NORMAL: next_word = in;
      WORD_LAST:   next_word = last_word;
      WORD_FILL:   next_word = '0;
      default:     next_word = in;
    endcase
    if (final_slot) begin
      next_word[7:0] = next_word[7:0] | PAD_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide block register is reset too, so a consumer never sees stale data after reset.
      out   <= '0;
      count <= '0;
      pad   <= 1'b0;
      done  <= 1'b0;
    end else if (f_ack) begin
      count <= '0;
    end else if (update) begin
      // NOTE: non-blocking assignments, so every term on the right reads the pre-edge state.
      out   <= {out[RATE_W-WORD_W-1:0], next_word};
      count <= count + 1'b1;
      if (kind == WORD_LAST) begin
        pad <= 1'b1;
      end
      // Completing a padded block closes the message; this also covers a
      // last word that lands directly in slot 8.
      if (final_slot) begin
        pad  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keccak_padder64.sv
// Self-checking bench for keccak_padder64: directed scenarios plus randomized
// messages checked against a byte-level SHA3 padding model.
module tb_keccak_padder64;
  import keccak_pkg::*;

  localparam logic [63:0] W = 64'h1234567890ABCDEF;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  din;
  logic         in_ready;
  logic         is_last;
  logic [2:0]   byte_num;
  logic         buffer_full;
  logic [575:0] dout;
  logic         out_ready;
  logic         f_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // Padded message bytes for the randomized test.
  byte unsigned pm[$];

  keccak_padder64 dut (
    .clk         (clk),
    .reset       (reset),
    .in          (din),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (dout),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    reset = 1'b1; f_ack = 1'b0; in_ready = 1'b0; is_last = 1'b0;
    byte_num = 3'd0; din = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] bn);
    din = d; is_last = last; byte_num = bn; in_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic pulse_ack();
    f_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    f_ack = 1'b0;
  endtask

  // Counts falling edges until out_ready, capped at 20.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!out_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic logic [575:0] model_block(input int j);
    logic [575:0] b;
    b = '0;
    for (int i = 0; i < 72; i++) b[575-8*i -: 8] = pm[72*j+i];
    return b;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dout !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: out=%h ready=%b full=%b, expected all zero", dout, out_ready, buffer_full);
    end
    for (int i = 0; i < 5; i++) send_word(W, 1'b0, 3'd0);
    do_reset();
    n_cmp++;
    if (dout !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_block: out=%h, expected 0", dout);
    end
    for (int i = 0; i < 8; i++) send_word(W, 1'b0, 3'd0);
    n_cmp++;
    if (buffer_full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: buffer_full=%b after 8 words, expected 0", buffer_full);
    end
    send_word(W, 1'b0, 3'd0);
    n_cmp++;
    if (buffer_full !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_refill: buffer_full=%b after 9 words, expected 1", buffer_full);
    end
  endtask

  task automatic test_empty();
    int cyc;
    do_reset();
    din = {$urandom(), $urandom()}; is_last = 1'b1; byte_num = 3'd0; in_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0;
    wait_ready(cyc);
    n_cmp++;
    if (cyc != 7) begin
      n_bad++;
      $display("FAIL empty_latency: got %0d cycles, expected 7", cyc);
    end
    n_cmp++;
    if (dout !== {8'h06, 560'h0, 8'h80}) begin
      n_bad++;
      $display("FAIL empty_block: out=%h expected=%h", dout, {8'h06, 560'h0, 8'h80});
    end
    in_ready = 1'b1; is_last = 1'b1;
    pulse_ack();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (buffer_full !== 1'b0) begin
        n_bad++;
        $display("FAIL empty_after_done[%0d]: buffer_full=%b expected 0", i, buffer_full);
      end
      @(negedge clk);
    end
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic test_partial_word(input logic [63:0] d, input logic [2:0] bn,
                                   input logic [63:0] exp_first, input string name);
    int cyc;
    logic [575:0] exp;
    do_reset();
    send_word(d, 1'b1, bn);
    wait_ready(cyc);
    n_cmp++;
    if (cyc != 8) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, expected 8", name, cyc);
    end
    exp = {exp_first, 504'h0, 8'h80};
    n_cmp++;
    if (dout !== exp) begin
      n_bad++;
      $display("FAIL %s_block: out=%h expected=%h", name, dout, exp);
    end
  endtask

  task automatic test_slot9_last(input logic [63:0] d, input logic [2:0] bn,
                                 input logic [63:0] exp_last, input string name);
    int cyc;
    logic [575:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) send_word(W, 1'b0, 3'($urandom_range(0, 7)));
    send_word(d, 1'b1, bn);
    wait_ready(cyc);
    n_cmp++;
    if (cyc != 0) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, expected 0", name, cyc);
    end
    exp = {{8{W}}, exp_last};
    n_cmp++;
    if (dout !== exp) begin
      n_bad++;
      $display("FAIL %s_block: out=%h expected=%h", name, dout, exp);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [575:0] exp;
    do_reset();
    for (int i = 0; i < 9; i++) send_word(W, 1'b0, 3'd0);
    n_cmp++;
    if (out_ready !== 1'b1 || dout !== {9{W}}) begin
      n_bad++;
      $display("FAIL b2b_first_block: ready=%b out=%h expected=%h", out_ready, dout, {9{W}});
    end
    din = 64'h999; in_ready = 1'b1; is_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_ready !== 1'b1 || dout !== {9{W}}) begin
      n_bad++;
      $display("FAIL b2b_hold_while_full: ready=%b out=%h expected=%h", out_ready, dout, {9{W}});
    end
    // Word still offered during the ack cycle must not be taken.
    pulse_ack();
    in_ready = 1'b0;
    n_cmp++;
    if (out_ready !== 1'b0 || dout !== {9{W}}) begin
      n_bad++;
      $display("FAIL b2b_after_ack: ready=%b out=%h expected ready=0 out=%h", out_ready, dout, {9{W}});
    end
    for (int i = 0; i < 8; i++) send_word(W, 1'b0, 3'd0);
    n_cmp++;
    if (buffer_full !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_partial: buffer_full=%b after 8 words, expected 0", buffer_full);
    end
    send_word(W, 1'b1, 3'd2);
    wait_ready(cyc);
    exp = {{8{W}}, 64'h1234060000000080};
    n_cmp++;
    if (cyc != 0 || dout !== exp) begin
      n_bad++;
      $display("FAIL b2b_second_block: cycles=%0d out=%h expected cycles=0 out=%h", cyc, dout, exp);
    end
    in_ready = 1'b1; is_last = 1'b1;
    pulse_ack();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_closed[%0d]: out_ready=%b expected 0", i, out_ready);
      end
      @(negedge clk);
    end
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      byte unsigned msg[$];
      int len, nwords, blk, cyc, k;
      logic [63:0] d;
      logic [2:0] bn;
      logic last;
      len = $urandom_range(0, 220);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      // SHA3 padding: domain byte, zero fill to a whole block, final bit.
      pm = msg;
      pm.push_back(8'h06);
      while (pm.size() % 72 != 0) pm.push_back(8'h00);
      pm[pm.size()-1] = pm[pm.size()-1] | 8'h80;

      do_reset();
      nwords = len / 8 + 1;
      blk = 0;
      for (int wi = 0; wi < nwords; wi++) begin
        last = (wi == nwords - 1);
        for (int b = 0; b < 8; b++) begin
          d[63-8*b -: 8] = (wi*8 + b < len) ? msg[wi*8+b] : 8'($urandom());
        end
        bn = last ? 3'(len % 8) : 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); @(negedge clk);
        end
        send_word(d, last, bn);
        if (!last) begin
          n_cmp++;
          if (out_ready !== (wi % 9 == 8)) begin
            n_bad++;
            $display("FAIL rnd%0d_ready_w%0d: out_ready=%b expected %b", it, wi, out_ready, (wi % 9 == 8));
          end
          if (wi % 9 == 8) begin
            n_cmp++;
            if (dout !== model_block(blk)) begin
              n_bad++;
              $display("FAIL rnd%0d_block%0d: out=%h expected=%h", it, blk, dout, model_block(blk));
            end
            blk++;
            pulse_ack();
          end
        end else begin
          k = wi % 9 + 1;
          wait_ready(cyc);
          n_cmp++;
          if (cyc != 9 - k) begin
            n_bad++;
            $display("FAIL rnd%0d_latency: len=%0d slot=%0d got %0d cycles, expected %0d", it, len, k, cyc, 9 - k);
          end
          n_cmp++;
          if (dout !== model_block(blk)) begin
            n_bad++;
            $display("FAIL rnd%0d_final%0d: len=%0d out=%h expected=%h", it, blk, len, dout, model_block(blk));
          end
          pulse_ack();
          n_cmp++;
          if (out_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd%0d_ack: out_ready=%b expected 0", it, out_ready);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_partial_word(64'h90ABCDEF1A1B1C1D, 3'd7, 64'h90ABCDEF1A1B1C06, "seven_byte");
    test_partial_word({32'h90ABCDEF, 32'($urandom())}, 3'd4, 64'h90ABCDEF06000000, "four_byte");
    test_slot9_last(W, 3'd7, 64'h1234567890ABCD86, "msg568");
    test_slot9_last({$urandom(), $urandom()}, 3'd0, 64'h0600000000000080, "msg512");
    test_back_to_back();
    test_random(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
